// File: rtl/image_scanout.sv
// image_scanout: VGA timing and BRAM scan-out of the decrypted image, shown whole frames only
module image_scanout #(
  parameter int          IMG_W    = 175,
  parameter int          IMG_H    = 175,
  parameter int          X_OFF    = 232,
  parameter int          Y_OFF    = 152,
  parameter logic [7:0]  BG_COLOR = 8'h00,
  parameter int          H_ACT    = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACT    = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        decrypt_done,
  input  logic [7:0]  pixel_data,
  output logic [14:0] read_addr,
  output logic [7:0]  rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic        displaying
);
  localparam logic [9:0]  H_MAX = 10'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0]  V_MAX = 10'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  H_A   = 10'(H_ACT);
  localparam logic [9:0]  V_A   = 10'(V_ACT);
  localparam logic [9:0]  H_END = 10'(H_ACT - 1);
  localparam logic [9:0]  HS_LO = 10'(H_ACT + H_FP);
  localparam logic [9:0]  HS_HI = 10'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [9:0]  VS_LO = 10'(V_ACT + V_FP);
  localparam logic [9:0]  VS_HI = 10'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [9:0]  X_LO  = 10'(X_OFF);
  localparam logic [9:0]  X_HI  = 10'(X_OFF + IMG_W - 1);
  localparam logic [9:0]  Y_LO  = 10'(Y_OFF);
  localparam logic [9:0]  Y_HI  = 10'(Y_OFF + IMG_H - 1);
  localparam logic [14:0] W15   = 15'(IMG_W);

  typedef enum logic [1:0] {IDLE, ARMED, SHOW} state_t;

  state_t      state_q, state_d;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [14:0] row_base_q, row_base_d, addr_d;
  logic        at_origin, img_line, in_img, active, hs_raw, vs_raw;
  logic        in_img_q1, act_q1, hs_q1, vs_q1;
  logic        in_img_q2, act_q2, hs_q2, vs_q2;

  // counter stepping, image window decode and multiplier-free address generation
  always_comb begin
    at_origin  = h_q == 10'd0 && v_q == 10'd0;
    h_d        = h_q == H_MAX ? 10'd0 : h_q + 10'd1;
    v_d        = h_q != H_MAX ? v_q : (v_q == V_MAX ? 10'd0 : v_q + 10'd1);
    img_line   = v_q >= Y_LO && v_q <= Y_HI;
    in_img     = state_q == SHOW && img_line && h_q >= X_LO && h_q <= X_HI;
    active     = h_q < H_A && v_q < V_A;
    hs_raw     = !(h_q >= HS_LO && h_q <= HS_HI);
    vs_raw     = !(v_q >= VS_LO && v_q <= VS_HI);
    row_base_d = at_origin ? 15'd0 : (img_line && h_q == H_END) ? row_base_q + W15 : row_base_q;
    addr_d     = in_img ? row_base_q + 15'(h_q - X_LO) : read_addr;
  end

  // display FSM: arm on done, start only at a frame boundary, stop only at a frame boundary
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = decrypt_done ? ARMED : IDLE;
      ARMED:   state_d = at_origin ? SHOW : (decrypt_done ? ARMED : IDLE);
      SHOW:    state_d = (at_origin && !decrypt_done) ? IDLE : SHOW;
      default: state_d = IDLE;
    endcase
  end

  // timing counters, FSM state and first pipeline stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_q         <= '0;
      v_q         <= '0;
      state_q     <= IDLE;
      row_base_q  <= '0;
      read_addr   <= '0;
      in_img_q1   <= 1'b0;
      act_q1      <= 1'b0;
      hs_q1       <= 1'b1;
      vs_q1       <= 1'b1;
      frame_start <= 1'b0;
      displaying  <= 1'b0;
    end else begin
      h_q         <= h_d;
      v_q         <= v_d;
      state_q     <= state_d;
      row_base_q  <= row_base_d;
      read_addr   <= addr_d;
      in_img_q1   <= in_img;
      act_q1      <= active;
      hs_q1       <= hs_raw;
      vs_q1       <= vs_raw;
      frame_start <= at_origin;
      displaying  <= state_q == SHOW;
    end
  end

  // second stage waits out the BRAM latency, third stage drives the pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_img_q2 <= 1'b0;
      act_q2    <= 1'b0;
      hs_q2     <= 1'b1;
      vs_q2     <= 1'b1;
      rgb       <= 8'h00;
      hsync     <= 1'b1;
      vsync     <= 1'b1;
    end else begin
      in_img_q2 <= in_img_q1;
      act_q2    <= act_q1;
      hs_q2     <= hs_q1;
      vs_q2     <= vs_q1;
      rgb       <= in_img_q2 ? pixel_data : (act_q2 ? BG_COLOR : 8'h00);
      hsync     <= hs_q2;
      vsync     <= vs_q2;
    end
  end
endmodule

// File: tb/tb_image_scanout.sv
// tb_image_scanout: randomized frame-level reference check of image_scanout on a shrunk raster
module tb_image_scanout;
  localparam int HA = 40, HF = 4, HS = 6, HB = 6;
  localparam int VA = 30, VF = 2, VS = 2, VB = 3;
  localparam int IW = 10, IH = 8, XO = 15, YO = 11;
  localparam logic [7:0] BG = 8'h5A;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int N  = IW * IH;

  logic        clk = 1'b0, reset = 1'b0, decrypt_done = 1'b0;
  logic [7:0]  pixel_data = 8'h00;
  logic [14:0] read_addr;
  logic [7:0]  rgb;
  logic        hsync, vsync, frame_start, displaying;

  image_scanout #(
    .IMG_W(IW), .IMG_H(IH), .X_OFF(XO), .Y_OFF(YO), .BG_COLOR(BG),
    .H_ACT(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACT(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .reset(reset), .decrypt_done(decrypt_done), .pixel_data(pixel_data),
    .read_addr(read_addr), .rgb(rgb), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .displaying(displaying)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:32767];
  always @(posedge clk) pixel_data <= mem[read_addr];

  int checks = 0, errors = 0;
  int k = 0, exp_addr = 0, q1 = 0, q3 = 0;
  bit shown [0:63];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, k);
    end
  endtask

  function automatic int hp(input int q); return q % HT; endfunction
  function automatic int vp(input int q); return (q / HT) % VT; endfunction

  function automatic bit show_at(input int q);
    int f = q / FR;
    if (q % FR != 0) return shown[f];
    return f > 0 && shown[f-1];
  endfunction

  function automatic bit img_at(input int q);
    if (q < 0) return 1'b0;
    return show_at(q) && hp(q) >= XO && hp(q) < XO + IW && vp(q) >= YO && vp(q) < YO + IH;
  endfunction

  function automatic int addr_at(input int q);
    return (vp(q) - YO) * IW + (hp(q) - XO);
  endfunction

  function automatic int exp_rgb(input int q);
    if (q < 0) return 0;
    if (img_at(q)) return int'(mem[addr_at(q)]);
    return (hp(q) < HA && vp(q) < VA) ? int'(BG) : 0;
  endfunction

  function automatic int exp_hs(input int q);
    return (q >= 0 && hp(q) >= HA + HF && hp(q) < HA + HF + HS) ? 0 : 1;
  endfunction

  function automatic int exp_vs(input int q);
    return (q >= 0 && vp(q) >= VA + VF && vp(q) < VA + VF + VS) ? 0 : 1;
  endfunction

  // k counts clock edges since reset release; the raster position equals k modulo the frame
  always @(negedge clk) begin
    if (reset) begin
      k = 0;
      exp_addr = 0;
      for (int i = 0; i < 64; i++) shown[i] = 1'b0;
    end else begin
      k++;
      if (k % FR == 0 && k / FR < 64) shown[k / FR] = decrypt_done;
      q1 = k - 1;
      q3 = k - 3;
      if (img_at(q1)) exp_addr = addr_at(q1);
      check("read_addr", int'(read_addr), exp_addr);
      check("frame_start", int'(frame_start), int'(q1 % FR == 0));
      check("displaying", int'(displaying), int'(show_at(q1)));
      check("hsync", int'(hsync), exp_hs(q3));
      check("vsync", int'(vsync), exp_vs(q3));
      check("rgb", int'(rgb), exp_rgb(q3));
    end
  end

  task automatic goto(input int target);
    while (k < target) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set_done_in_frame(input int f, input bit val);
    goto(f * FR + int'($urandom_range(60, FR - 60)));
    decrypt_done = val;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_rgb"}, int'(rgb), 0);
    check({pfx, "_hsync"}, int'(hsync), 1);
    check({pfx, "_vsync"}, int'(vsync), 1);
    check({pfx, "_addr"}, int'(read_addr), 0);
    check({pfx, "_fs"}, int'(frame_start), 0);
    check({pfx, "_disp"}, int'(displaying), 0);
  endtask

  initial begin
    int f;
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;
    goto(2 * FR + 10);
    set_done_in_frame(2, 1'b1);
    goto(5 * FR + 50);
    check("max_addr", int'(read_addr), N - 1);
    set_done_in_frame(5, 1'b0);
    goto(8 * FR);
    goto(8 * FR + int'($urandom_range(60, FR / 2)));
    decrypt_done = 1'b1;
    goto(k + int'($urandom_range(5, 200)));
    decrypt_done = 1'b0;
    goto(10 * FR);
    for (int i = 0; i < 6; i++) begin
      f = k / FR;
      set_done_in_frame(f, 1'($urandom));
      goto((f + 1) * FR + 30);
    end
    f = k / FR;
    set_done_in_frame(f, 1'b1);
    goto((f + 2) * FR + (YO + 3) * HT + XO + 4);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check_reset_values("async_rst");
    @(negedge clk);
    #1 reset = 1'b0;
    goto(2 * FR + (YO + IH) * HT);
    decrypt_done = 1'b0;
    goto(3 * FR + 100);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
